// File: rtl/thermal_lock_ctrl_if.sv
// -----------------------------------------------------------------------------
// thermal_lock_ctrl_if
// Purpose : groups the lock-loop control, receiver-decision inputs and the
//           heater/status outputs of thermal_lock_ctrl into one bundle.
// Signals : en, rx_valid, rx_bit, exp_bit      -> controller
//           heater_pdm, heater_code, err_count,
//           locked, busy                       <- controller
// Modports: master drives the inputs and observes the status (bench / host),
//           slave is the controller side.
// -----------------------------------------------------------------------------
interface thermal_lock_ctrl_if #(
   parameter int CODE_W = 8,
   parameter int WINDOW = 256
);
   localparam int CNT_W = $clog2(WINDOW + 1);

   logic              en;
   logic              rx_valid;
   logic              rx_bit;
   logic              exp_bit;
   logic              heater_pdm;
   logic [CODE_W-1:0] heater_code;
   logic [CNT_W-1:0]  err_count;
   logic              locked;
   logic              busy;

   modport master (
      output en, rx_valid, rx_bit, exp_bit,
      input  heater_pdm, heater_code, err_count, locked, busy
   );

   modport slave (
      input  en, rx_valid, rx_bit, exp_bit,
      output heater_pdm, heater_code, err_count, locked, busy
   );
endinterface

// File: rtl/thermal_lock_ctrl.sv
// -----------------------------------------------------------------------------
// thermal_lock_ctrl
// Purpose : closed-loop heater tuning. Counts receiver bit errors over a
//           window of WINDOW samples, then steps the heater code one LSB in
//           the direction that reduces errors (hill climb), waits
//           SETTLE_CYCLES for the thermal tuner to settle and measures again.
//           The heater code is turned into a pulse-density stream by a
//           first-order accumulator.
// Ports   : clk    - single clock, rising edge
//           rst_n  - synchronous active-low reset
//           bus    - thermal_lock_ctrl_if.slave (en, rx_valid, rx_bit,
//                    exp_bit in; heater_pdm, heater_code, err_count,
//                    locked, busy out)
// -----------------------------------------------------------------------------
module thermal_lock_ctrl #(
   parameter int CODE_W        = 8,
   parameter int WINDOW        = 256,
   parameter int SETTLE_CYCLES = 1000,
   parameter int LOCK_THRESH   = 0,
   parameter int INIT_CODE     = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   thermal_lock_ctrl_if.slave  bus
);
   localparam int CNT_W = $clog2(WINDOW + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
   localparam logic [CODE_W-1:0] CODE_ZERO = {CODE_W{1'b0}};
   localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);
   localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(INIT_CODE);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW - 1);
   localparam logic [SET_W-1:0]  SET_ZERO  = {SET_W{1'b0}};
   localparam logic [SET_W-1:0]  SET_ONE   = SET_W'(1);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_DECIDE  = 2'd2,
      ST_SETTLE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              dir_up_q, dir_up_d;     // 1 = next step increments code
   logic              first_q, first_d;       // no DECIDE since IDLE yet
   logic [CNT_W-1:0]  prev_q, prev_d;         // total of previous window
   logic [CNT_W-1:0]  smp_q, smp_d;
   logic [CNT_W-1:0]  err_acc_q, err_acc_d;
   logic [SET_W-1:0]  set_q, set_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic              locked_q, locked_d;
   logic [CODE_W-1:0] acc_q, acc_d;
   logic              pdm_q, pdm_d;

   logic              sample_err_s;
   logic              over_thresh_s;
   logic              step_up_s;
   logic              busy_s;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; en low forces IDLE from any state
   always_comb begin
      state_d = state_q;
      if (!bus.en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
               if (bus.rx_valid && (smp_q == WIN_LAST)) begin
                  state_d = ST_DECIDE;
               end else begin
                  state_d = ST_MEASURE;
               end
            end
            ST_DECIDE: begin
               state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (set_q == SET_LAST) begin
                  state_d = ST_MEASURE;
               end else begin
                  state_d = ST_SETTLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // FSM output logic
   always_comb begin
      busy_s = 1'b0;
      case (state_q)
         ST_IDLE:    busy_s = 1'b0;
         ST_MEASURE: busy_s = 1'b1;
         ST_DECIDE:  busy_s = 1'b1;
         ST_SETTLE:  busy_s = 1'b1;
         default:    busy_s = 1'b0;
      endcase
   end

   // Per-state datapath: window counters, hill-climb decision, settle timer
   always_comb begin
      code_d        = code_q;
      dir_up_d      = dir_up_q;
      first_d       = first_q;
      prev_d        = prev_q;
      smp_d         = smp_q;
      err_acc_d     = err_acc_q;
      set_d         = set_q;
      err_count_d   = err_count_q;
      locked_d      = locked_q;

      sample_err_s  = bus.rx_bit ^ bus.exp_bit;
      over_thresh_s = 32'(err_acc_q) > 32'(LOCK_THRESH);
      // Reverse only when this window got worse than the last one
      if (first_q) begin
         step_up_s = dir_up_q;
      end else if (err_acc_q > prev_q) begin
         step_up_s = ~dir_up_q;
      end else begin
         step_up_s = dir_up_q;
      end

      if (!bus.en) begin
         // Leaving for IDLE: restart the search cleanly, keep code/status
         smp_d     = CNT_ZERO;
         err_acc_d = CNT_ZERO;
         set_d     = SET_ZERO;
         dir_up_d  = 1'b1;
         first_d   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               smp_d     = CNT_ZERO;
               err_acc_d = CNT_ZERO;
               set_d     = SET_ZERO;
               dir_up_d  = 1'b1;
               first_d   = 1'b1;
            end
            ST_MEASURE: begin
               if (bus.rx_valid) begin
                  smp_d     = smp_q + CNT_ONE;
                  err_acc_d = err_acc_q + {{(CNT_W-1){1'b0}}, sample_err_s};
               end else begin
                  smp_d     = smp_q;
                  err_acc_d = err_acc_q;
               end
            end
            ST_DECIDE: begin
               err_count_d = err_acc_q;
               prev_d      = err_acc_q;
               first_d     = 1'b0;
               smp_d       = CNT_ZERO;
               err_acc_d   = CNT_ZERO;
               set_d       = SET_ZERO;
               if (over_thresh_s) begin
                  locked_d = 1'b0;
                  // At either end of the code range, hold the code and turn
                  // around instead of wrapping
                  if (step_up_s && (code_q == CODE_MAX)) begin
                     dir_up_d = 1'b0;
                  end else if (!step_up_s && (code_q == CODE_ZERO)) begin
                     dir_up_d = 1'b1;
                  end else if (step_up_s) begin
                     code_d   = code_q + CODE_ONE;
                     dir_up_d = 1'b1;
                  end else begin
                     code_d   = code_q - CODE_ONE;
                     dir_up_d = 1'b0;
                  end
               end else begin
                  locked_d = 1'b1;
               end
            end
            ST_SETTLE: begin
               if (set_q == SET_LAST) begin
                  set_d = SET_ZERO;
               end else begin
                  set_d = set_q + SET_ONE;
               end
            end
            default: begin
               smp_d     = CNT_ZERO;
               err_acc_d = CNT_ZERO;
               set_d     = SET_ZERO;
            end
         endcase
      end
   end

   // First-order PDM: carry out of acc + code is the heater pulse
   always_comb begin
      {pdm_d, acc_d} = {1'b0, acc_q} + {1'b0, code_q};
   end

   // Datapath and PDM registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         code_q      <= CODE_INIT;
         dir_up_q    <= 1'b1;
         first_q     <= 1'b1;
         prev_q      <= CNT_ZERO;
         smp_q       <= CNT_ZERO;
         err_acc_q   <= CNT_ZERO;
         set_q       <= SET_ZERO;
         err_count_q <= CNT_ZERO;
         locked_q    <= 1'b0;
         acc_q       <= CODE_ZERO;
         pdm_q       <= 1'b0;
      end else begin
         code_q      <= code_d;
         dir_up_q    <= dir_up_d;
         first_q     <= first_d;
         prev_q      <= prev_d;
         smp_q       <= smp_d;
         err_acc_q   <= err_acc_d;
         set_q       <= set_d;
         err_count_q <= err_count_d;
         locked_q    <= locked_d;
         acc_q       <= acc_d;
         pdm_q       <= pdm_d;
      end
   end

   assign bus.heater_pdm  = pdm_q;
   assign bus.heater_code = code_q;
   assign bus.err_count   = err_count_q;
   assign bus.locked      = locked_q;
   assign bus.busy        = busy_s;

endmodule

// File: doc/thermal_lock_ctrl.md
THERMAL_LOCK_CTRL -- requirements
Module: thermal_lock_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 8, heater code width.
REQ-002 SHALL have parameter WINDOW, default 256, received bits per measurement window (power of 2, >=4).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1000, clocks waited after each code change.
REQ-004 SHALL have parameter LOCK_THRESH, default 0, max window errors counted as locked.
REQ-005 SHALL have parameter INIT_CODE, default 0, heater code after reset.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 en  input  1  1 = run lock loop; 0 = hold code, return to IDLE.
REQ-009 rx_valid  input  1  one receiver decision presented this cycle.
REQ-010 rx_bit  input  1  receiver output bit; sampled only when rx_valid=1.
REQ-011 exp_bit  input  1  expected training bit, aligned with rx_bit.
REQ-012 heater_pdm  output  1  pulse-density heater drive to the thermal tuner.
REQ-013 heater_code  output  CODE_W  current heater code.
REQ-014 err_count  output  clog2(WINDOW+1)  error total of last completed window.
REQ-015 locked  output  1  last window errors <= LOCK_THRESH.
REQ-016 busy  output  1  state != IDLE.

Function
REQ-017 SHALL implement states IDLE, MEASURE, DECIDE, SETTLE.
REQ-018 IDLE -> MEASURE on the first cycle en=1; any state -> IDLE on the cycle after en=0 is sampled.
REQ-019 MEASURE: each cycle with rx_valid=1 counts one sample; error counted when rx_bit != exp_bit.
REQ-020 The cycle accepting the WINDOW-th sample SHALL be the last MEASURE cycle; DECIDE follows for exactly 1 cycle.
REQ-021 DECIDE SHALL load err_count with the window total (including the final sample) and clear sample/error counters.
REQ-022 DECIDE, total <= LOCK_THRESH: locked=1, heater_code unchanged.
REQ-023 DECIDE, total > LOCK_THRESH: locked=0; if first window since IDLE, keep dir; else if total > previous total, invert dir; then step code by 1 in dir.
REQ-024 Direction dir SHALL be up after reset and on every IDLE entry.
REQ-025 Step at code 2^CODE_W-1 going up, or 0 going down: code unchanged (clamp) and dir inverted.
REQ-026 The window total SHALL be stored as previous total in every DECIDE.
REQ-027 SETTLE SHALL last exactly SETTLE_CYCLES cycles, rx_valid ignored, then MEASURE; SETTLE is entered after every DECIDE, including locked/unchanged cases.
REQ-028 heater_pdm SHALL be the carry of a CODE_W-bit accumulator: {carry,acc} <= acc + heater_code every cycle, in all states.
REQ-029 Over any 2^CODE_W consecutive cycles at constant code, heater_pdm high count SHALL equal heater_code exactly.
REQ-030 en=0 SHALL retain heater_code, locked and err_count; PDM continues; counters cleared.
REQ-031 en toggling 0->1 mid-window SHALL restart a fresh window (partial counts discarded, first-window rule applies).

Reset
REQ-032 On rst_n=0 at a clock edge: state=IDLE, heater_code=INIT_CODE, acc=0, heater_pdm=0, err_count=0, locked=0, busy=0, dir=up, counters and previous total cleared.
REQ-033 Reset SHALL override en and any in-progress window in the same cycle.

Verification
REQ-034 WINDOW=4, SETTLE_CYCLES=2, en=1, 4 valid samples, 2 mismatches -> DECIDE: err_count=2, locked=0, heater_code 0->1; SETTLE 2 cycles; MEASURE resumes.
REQ-035 Window totals 3 then 5 -> second DECIDE inverts dir, heater_code decrements 2->1.
REQ-036 Window with 0 mismatches, LOCK_THRESH=0 -> locked=1, code held; next window 1 error -> locked=0, code steps.
REQ-037 INIT_CODE=255, dir up, window errors>0 -> code stays 255, dir becomes down, next step gives 254.
REQ-038 heater_code=64 held, CODE_W=8 -> exactly 64 heater_pdm highs per 256 cycles; code 0 -> never high.
REQ-039 rst_n=0 mid-MEASURE with 3 samples counted -> next cycle all outputs at REQ-032 values, busy=0.
